load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit. Consumes the EX-stage ALU result (effective address) and rs2 store data,
//  runs one data-memory transaction over a req/gnt/rvalid bus, aligns/extends load data and stalls the
//  pipeline until done. Output feeds the MEM/WB pipeline register.
// PARAMETERS
//  ADDR_W  32  byte-address width (mem_addr is ADDR_W bits, low 2 bits forced 0)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   MEM stage holds a load/store; held until lsu_busy=0
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3: LB 000 LH 001 LW 010 LBU 100 LHU 101 / SB 000 SH 001 SW 010
//  req_addr    in   32  effective address (ALU AluOut)
//  req_wdata   in   32  store data (rs2)
//  flush       in   1   kill in-flight op result (from hazard unit)
//  mem_req     out  1   bus request; held with addr/we/be/wdata stable until mem_gnt
//  mem_we      out  1   bus write enable
//  mem_addr    out  32  word-aligned address
//  mem_be      out  4   byte enables (store); 4'b1111 on loads
//  mem_wdata   out  32  lane-replicated store data
//  mem_gnt     in   1   request accepted this cycle
//  mem_rvalid  in   1   load data valid (>=1 cycle after gnt)
//  mem_rdata   in   32  load word
//  lsu_busy    out  1   stall request to hazard unit
//  rsp_valid   out  1   1-cycle pulse: op complete, rsp_* valid
//  rsp_rdata   out  32  extended load result (0 for stores/errors)
//  rsp_err     out  1   misaligned or illegal funct3; no bus access made
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; every output 0; kill flag clear; in-flight transaction abandoned,
//   later mem_gnt/mem_rvalid ignored until a new request is issued.
//  FSM states IDLE, REQ, WAIT, DONE:
//   IDLE: req_valid & !flush & legal & aligned -> latch addr/we/be/wdata/funct3, go REQ.
//         req_valid & !flush & (illegal | misaligned) -> go DONE with rsp_err=1.
//   REQ : mem_req=1. On mem_gnt: store -> DONE; load -> WAIT. Never drop mem_req before gnt.
//   WAIT: on mem_rvalid capture extended data -> DONE. rvalid in same cycle as gnt is not legal bus use.
//   DONE: rsp_valid=1 one cycle, then IDLE. No acceptance in DONE (stage advances at end of this cycle).
//  lsu_busy = (IDLE & req_valid & !flush) | REQ | WAIT; 0 in DONE.
//  Min latency req_valid->rsp_valid: store 2 cycles (gnt in first REQ cycle), load 3 (rvalid next cycle).
//  Alignment: half needs addr[0]=0, word needs addr[1:0]=0. Illegal: load funct3 011/110/111; store >=011.
//  Store lanes (off=addr[1:0]): SB be=4'b0001<<off, wdata={4{d[7:0]}}; SH be=4'b0011<<off, wdata={2{d[15:0]}};
//   SW be=4'b1111, wdata=d.
//  Load extract: LB/LBU byte rdata[8*off+:8] sign/zero-extended; LH/LHU half rdata[16*addr[1]+:16]; LW as-is.
//  Flush in REQ/WAIT: set kill; bus transaction still completes (stores still write memory); at
//   completion go IDLE instead of DONE, no rsp_valid. Flush in DONE: rsp_valid suppressed. Flush in IDLE: no accept.
//  rsp_rdata/rsp_err hold their value outside DONE; cleared on next acceptance.
// STRUCTURE
//  Parameters.v: add LSU funct3 codes (`LB..`LHU, `SB..`SW) as defines; FSM encoding stays local.
//  Sub-module lsu_align (combinational): store be/wdata generation and load extract/extend; unit-tested alone.
// TESTING
//  SW addr 0x100 data 0xDEADBEEF, gnt on first REQ cycle -> mem_addr 0x100, be 1111, rsp_valid 2 cycles later.
//  Load rdata 0x80FF1234: LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080; LH @0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
//  SB addr 0x201 data 0x000000AB -> be 4'b0010, wdata 0xABABABAB; SH @0x202 data 0x1234 -> be 1100, wdata 0x12341234.
//  LW @0x102 -> no mem_req, rsp_valid & rsp_err =1 next cycle, rsp_rdata 0; funct3 011 load -> same.
//  gnt delayed 3 cycles, rvalid 2 after gnt -> mem_* stable throughout REQ, lsu_busy high until DONE;
//   repeat with flush pulse in WAIT -> no rsp_valid, IDLE after rvalid.
//  rst_n low in WAIT -> outputs 0 asynchronously; stale rvalid after reset -> no rsp_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: RV32I load/store funct3 codes shared by the LSU and its aligner
package load_store_unit_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: store byte-enable/lane replication, load extract/extend, legality and alignment check
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        err
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        illegal;
  logic        misaligned;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    illegal = we ? (funct3 > SW) : !(funct3 inside {LB, LH, LW, LBU, LHU});
    misaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
    err = illegal | misaligned;
    be = !we ? 4'b1111 : funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata = funct3[1:0] == 2'b00 ? {4{sdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{sdata[15:0]}} : sdata;
    ldata = funct3 == LB  ? {{24{b[7]}}, b} :
            funct3 == LBU ? {24'b0, b} :
            funct3 == LH  ? {{16{h[15]}}, h} :
            funct3 == LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage LSU running one req/gnt/rvalid bus transaction per op and stalling until done
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              lsu_busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t            state, nstate;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              kill_q;
  logic              idle, accept, in_bus;
  logic [3:0]        a_be;
  logic [31:0]       a_wdata, a_ldata;
  logic              a_err;
  assign idle   = state == IDLE;
  assign accept = idle & req_valid & !flush;
  assign in_bus = state == REQ || state == WAIT;
  // one aligner serves both directions: request fields while idle, latched op afterwards
  lsu_align u_align (
    .we     (idle ? req_we : we_q),
    .funct3 (idle ? req_funct3 : f3_q),
    .off    (idle ? req_addr[1:0] : addr_q[1:0]),
    .sdata  (req_wdata),
    .rdata  (mem_rdata),
    .be     (a_be),
    .wdata  (a_wdata),
    .ldata  (a_ldata),
    .err    (a_err)
  );
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = accept ? (a_err ? DONE : REQ) : IDLE;
      REQ:     nstate = !mem_gnt ? REQ : !we_q ? WAIT : (kill_q | flush) ? IDLE : DONE;
      WAIT:    nstate = !mem_rvalid ? WAIT : (kill_q | flush) ? IDLE : DONE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      kill_q    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state  <= nstate;
      kill_q <= (nstate != IDLE) & (kill_q | (flush & in_bus));
      if (accept) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        addr_q    <= req_addr;
        be_q      <= a_be;
        wdata_q   <= a_wdata;
        rsp_rdata <= '0;
        rsp_err   <= a_err;
      end
      if (state == WAIT && mem_rvalid) rsp_rdata <= a_ldata;
    end
  end
  assign mem_req   = state == REQ;
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign lsu_busy  = rst_n & (accept | in_bus);
  assign rsp_valid = state == DONE && !flush;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized ops checked each cycle against a spec-level timeline model
module tb_load_store_unit;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, flush = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, rsp_rdata;
  logic [3:0]  mem_be;
  logic        lsu_busy, rsp_valid, rsp_err;
  int          total = 0, bad = 0;
  logic        chk_on = 0;
  logic        exp_req = 0, exp_busy = 0, exp_rsp = 0, exp_we = 0, exp_err = 0;
  logic [31:0] exp_addr = 0, exp_wd = 0, exp_rdata = 0;
  logic [3:0]  exp_be = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .lsu_busy(lsu_busy), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
    end
  endtask

  // spec rules in plain arithmetic: access size in bytes, lane shift, replication, extension
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, d, w,
                                output logic err, output logic [3:0] be, output logic [31:0] wd, ld);
    int n, off;
    logic ill;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    err = ill || (off % n != 0);
    be  = we ? 4'(((1 << n) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % n) +: 8];
    v = w >> (8 * off);
    if (n == 1) v = (!f3[2] && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
    else if (n == 2) v = (!f3[2] && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
    ld = v;
  endfunction

  always @(negedge clk) if (chk_on) begin
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    chk("lsu_busy", {31'b0, lsu_busy}, {31'b0, exp_busy});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp});
    if (exp_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
    end
    if (exp_rsp) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, b, v);
    exp_req = r; exp_busy = b; exp_rsp = v;
  endtask

  // flp: cycle index after acceptance that carries a flush pulse (-1 none); pre: flushed cycle before accept
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a, d, w,
                        input int gd, input int rdl, input int flp, input logic pre);
    logic e, killed;
    logic [3:0] b;
    logic [31:0] wd, ld;
    int k;
    model(we, f3, a, d, w, e, b, wd, ld);
    exp_addr = {a[31:2], 2'b00}; exp_we = we; exp_be = b; exp_wd = wd;
    exp_rdata = (e || we) ? 32'h0 : ld; exp_err = e;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    if (pre) begin
      req_valid = 1; flush = 1; set_exp(0, 0, 0); step(); flush = 0;
    end
    req_valid = 1; set_exp(0, 1, 0); step();
    killed = 0; k = 1;
    if (!e) begin
      for (int i = 0; i <= gd; i++) begin
        mem_gnt = (i == gd); flush = (k == flp); killed |= flush;
        set_exp(1, 1, 0); step(); k++;
      end
      mem_gnt = 0;
      if (!we) for (int i = 1; i <= rdl; i++) begin
        mem_rvalid = (i == rdl); mem_rdata = (i == rdl) ? w : $urandom; flush = (k == flp); killed |= flush;
        set_exp(0, 1, 0); step(); k++;
      end
      mem_rvalid = 0; mem_rdata = $urandom;
    end
    if (!killed) begin
      flush = (k == flp); set_exp(0, 0, !flush); step();
    end
    req_valid = 0; flush = 0; set_exp(0, 0, 0);
  endtask

  initial begin
    logic e;
    logic [3:0] b;
    logic [31:0] wd, ld;
    logic [2:0] legal[8];
    legal = '{F_B, F_H, F_W, F_BU, F_HU, F_B, F_H, F_W};
    // hand-computed pins of the reference model
    model(0, F_B, 32'h103, 0, 32'h80FF1234, e, b, wd, ld);  chk("pin_lb", ld, 32'hFFFFFF80);
    model(0, F_BU, 32'h103, 0, 32'h80FF1234, e, b, wd, ld); chk("pin_lbu", ld, 32'h00000080);
    model(0, F_H, 32'h102, 0, 32'h80FF1234, e, b, wd, ld);  chk("pin_lh", ld, 32'hFFFF80FF);
    model(0, F_HU, 32'h102, 0, 32'h80FF1234, e, b, wd, ld); chk("pin_lhu", ld, 32'h000080FF);
    model(1, F_B, 32'h201, 32'hAB, 0, e, b, wd, ld);        chk("pin_sb_be", {28'b0, b}, 32'h2);
    chk("pin_sb_wd", wd, 32'hABABABAB);
    model(1, F_H, 32'h202, 32'h1234, 0, e, b, wd, ld);      chk("pin_sh_be", {28'b0, b}, 32'hC);
    chk("pin_sh_wd", wd, 32'h12341234);
    model(0, F_W, 32'h102, 0, 0, e, b, wd, ld);             chk("pin_lw_mis", {31'b0, e}, 32'h1);
    model(1, 3'b011, 32'h100, 0, 0, e, b, wd, ld);          chk("pin_s011", {31'b0, e}, 32'h1);
    #12;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_busy", {31'b0, lsu_busy}, 0);
    chk("rst_rsp", {rsp_err, rsp_valid, 30'b0}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_bus", {mem_we, mem_be, 27'b0} | mem_addr | mem_wdata, 0);
    @(posedge clk); #1; rst_n = 1; step();
    chk_on = 1;
    run_op(1, F_W, 32'h100, 32'hDEADBEEF, 0, 0, 1, -1, 0);
    run_op(0, F_B, 32'h103, 0, 32'h80FF1234, 0, 1, -1, 0);
    run_op(0, F_BU, 32'h103, 0, 32'h80FF1234, 1, 1, -1, 0);
    run_op(0, F_H, 32'h102, 0, 32'h80FF1234, 0, 1, -1, 0);
    run_op(0, F_HU, 32'h102, 0, 32'h80FF1234, 0, 2, -1, 0);
    run_op(1, F_B, 32'h201, 32'hAB, 0, 0, 1, -1, 0);
    run_op(1, F_H, 32'h202, 32'h1234, 0, 2, 1, -1, 0);
    run_op(0, F_W, 32'h102, 0, 0, 0, 1, -1, 0);
    run_op(0, 3'b011, 32'h100, 0, 0, 0, 1, -1, 0);
    run_op(0, F_W, 32'h300, 0, 32'hCAFEF00D, 3, 2, -1, 0);
    run_op(0, F_W, 32'h300, 0, 32'hCAFEF00D, 3, 2, 5, 0);
    run_op(1, F_W, 32'h304, 32'h55AA55AA, 0, 1, 1, 1, 0);
    run_op(1, F_W, 32'h308, 32'h11223344, 0, 0, 1, 2, 1);
    for (int n = 0; n < 300; n++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      int gd, rdl, len, flp;
      we  = 1'($urandom);
      f3  = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : 3'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      gd  = $urandom_range(0, 3);
      rdl = $urandom_range(1, 3);
      model(we, f3, a, 0, 0, e, b, wd, ld);
      len = e ? 1 : gd + 2 + (we ? 0 : rdl);
      flp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : -1;
      run_op(we, f3, a, $urandom, $urandom, gd, rdl, flp, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) step();
    end
    // asynchronous reset while a load waits for rvalid, then a stale rvalid/gnt
    chk_on = 0;
    req_we = 0; req_funct3 = F_W; req_addr = 32'h40; req_valid = 1; step();
    mem_gnt = 1; step();
    mem_gnt = 0; #2;
    rst_n = 0; #1;
    chk("arst_mem_req", {31'b0, mem_req}, 0);
    chk("arst_busy", {31'b0, lsu_busy}, 0);
    chk("arst_rsp", {rsp_err, rsp_valid, 30'b0}, 0);
    chk("arst_bus", {mem_we, mem_be, 27'b0} | mem_addr | mem_wdata | rsp_rdata, 0);
    req_valid = 0; step();
    rst_n = 1; mem_rvalid = 1; mem_gnt = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("stale_rsp0", {31'b0, rsp_valid}, 0);
    chk("stale_req0", {31'b0, mem_req}, 0);
    step(); mem_rvalid = 0; mem_gnt = 0;
    @(negedge clk);
    chk("stale_rsp1", {31'b0, rsp_valid}, 0);
    chk("stale_busy1", {31'b0, lsu_busy}, 0);
    step();
    chk_on = 1;
    run_op(0, F_H, 32'h52, 0, 32'h8001_7FFF, 0, 1, -1, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
